// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rc4_pkg
// Purpose : Shared types and constants for the RC4 pipeline (init, ksa,
//           prga). Holds the PRGA state encoding and the fixed layout
//           constants of the message RAMs.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package rc4_pkg;

    // Byte 0 of every CT/PT message holds the message length L.
    localparam int LEN_ADDR    = 0;
    // Clock cycles spent on each message byte by the PRGA loop.
    localparam int BYTE_CYCLES = 9;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LEN_RD   = 4'd1,
        LEN_WAIT = 4'd2,
        LEN_WR   = 4'd3,
        I_RD     = 4'd4,
        I_WAIT   = 4'd5,
        J_RD     = 4'd6,
        J_WAIT   = 4'd7,
        SWAP_I   = 4'd8,
        SWAP_J   = 4'd9,
        PAD_RD   = 4'd10,
        PAD_WAIT = 4'd11,
        PT_WR    = 4'd12
    } prga_state_t;

endpackage : rc4_pkg
`default_nettype wire

// File: rtl/rc4_prga.sv
`default_nettype none
// ============================================================================
// Module  : rc4_prga
// Purpose : RC4 pseudo-random generation / decrypt stage. Walks the
//           key-scheduled S permutation, swapping entries, and XORs each
//           keystream byte with the ciphertext read from CT RAM, writing
//           the plaintext to PT RAM. Byte 0 of a message is its length.
// Ports   : clk        - system clock
//           rst_n      - asynchronous active-low reset
//           en         - start request, honoured only while rdy=1
//           rdy        - idle and able to accept en
//           s_addr     - S RAM address        s_rddata  - S RAM read data
//           s_wrdata   - S RAM write data     s_wren    - S RAM write enable
//           ct_addr    - CT RAM address       ct_rddata - CT RAM read data
//           pt_addr    - PT RAM address       pt_wrdata - PT RAM write data
//           pt_wren    - PT RAM write enable
// Revision: 1.0 - initial release
// ============================================================================
module rc4_prga
    import rc4_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_rddata,
    output logic [DATA_W-1:0] s_wrdata,
    output logic              s_wren,
    output logic [ADDR_W-1:0] ct_addr,
    input  logic [DATA_W-1:0] ct_rddata,
    output logic [ADDR_W-1:0] pt_addr,
    output logic [DATA_W-1:0] pt_wrdata,
    output logic              pt_wren
);

    prga_state_t r_state;
    prga_state_t w_state_next;

    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W-1:0] r_j;
    // One bit wider than an address so that L=255 reaches k==len cleanly.
    logic [ADDR_W:0]   r_k;
    logic [DATA_W-1:0] r_len;
    logic [DATA_W-1:0] r_si;
    logic [DATA_W-1:0] r_sj;
    logic [DATA_W-1:0] r_ct_q;

    // All RAM-facing outputs are registered: a value set while in state X
    // reaches the RAM during the following cycle, the RAM registers it at
    // the end of that cycle, and read data is sampled one state later.
    logic [ADDR_W-1:0] r_s_addr;
    logic [DATA_W-1:0] r_s_wrdata;
    logic              r_s_wren;
    logic [ADDR_W-1:0] r_ct_addr;
    logic [ADDR_W-1:0] r_pt_addr;
    logic [DATA_W-1:0] r_pt_wrdata;
    logic              r_pt_wren;

    logic [ADDR_W-1:0] w_i_next;
    logic [ADDR_W-1:0] w_j_next;
    logic [ADDR_W-1:0] w_pad_addr;
    logic              w_last;

    // Index arithmetic is modulo 2**ADDR_W; carries are simply dropped.
    assign w_i_next   = r_i + ADDR_W'(1);
    assign w_j_next   = r_j + ADDR_W'(s_rddata);
    assign w_pad_addr = ADDR_W'(r_si + r_sj);
    assign w_last     = (r_k == (ADDR_W+1)'(r_len));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (en) w_state_next = LEN_RD;
            LEN_RD:   w_state_next = LEN_WAIT;
            LEN_WAIT: w_state_next = LEN_WR;
            // A zero-length message only copies its length byte.
            LEN_WR:   w_state_next = (ct_rddata == '0) ? IDLE : I_RD;
            I_RD:     w_state_next = I_WAIT;
            I_WAIT:   w_state_next = J_RD;
            J_RD:     w_state_next = J_WAIT;
            J_WAIT:   w_state_next = SWAP_I;
            SWAP_I:   w_state_next = SWAP_J;
            SWAP_J:   w_state_next = PAD_RD;
            PAD_RD:   w_state_next = PAD_WAIT;
            PAD_WAIT: w_state_next = PT_WR;
            PT_WR:    w_state_next = w_last ? IDLE : I_RD;
            default:  w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered RAM interface
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_len       <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_ct_q      <= '0;
            r_s_addr    <= '0;
            r_s_wrdata  <= '0;
            r_s_wren    <= 1'b0;
            r_ct_addr   <= '0;
            r_pt_addr   <= '0;
            r_pt_wrdata <= '0;
            r_pt_wren   <= 1'b0;
        end else begin
            // Write enables are single-cycle pulses.
            r_s_wren  <= 1'b0;
            r_pt_wren <= 1'b0;
            case (r_state)
                LEN_RD: begin
                    r_ct_addr <= ADDR_W'(LEN_ADDR);
                end
                LEN_WR: begin
                    r_len       <= ct_rddata;
                    r_pt_addr   <= ADDR_W'(LEN_ADDR);
                    r_pt_wrdata <= ct_rddata;
                    r_pt_wren   <= 1'b1;
                    r_i         <= '0;
                    r_j         <= '0;
                    r_k         <= (ADDR_W+1)'(1);
                end
                I_RD: begin
                    r_i       <= w_i_next;
                    r_s_addr  <= w_i_next;
                    r_ct_addr <= r_k[ADDR_W-1:0];
                end
                J_RD: begin
                    // s_rddata = S[i], ct_rddata = CT[k]
                    r_si     <= s_rddata;
                    r_ct_q   <= ct_rddata;
                    r_j      <= w_j_next;
                    r_s_addr <= w_j_next;
                end
                SWAP_I: begin
                    // s_rddata = S[j]; it becomes the new S[i].
                    r_sj       <= s_rddata;
                    r_s_addr   <= r_i;
                    r_s_wrdata <= s_rddata;
                    r_s_wren   <= 1'b1;
                end
                SWAP_J: begin
                    // When i==j both writes carry the same value, so S is
                    // left unchanged without any special handling.
                    r_s_addr   <= r_j;
                    r_s_wrdata <= r_si;
                    r_s_wren   <= 1'b1;
                end
                PAD_RD: begin
                    // The S[j] write lands at the end of this cycle, before
                    // the pad address is registered by the RAM.
                    r_s_addr <= w_pad_addr;
                end
                PT_WR: begin
                    r_pt_addr   <= r_k[ADDR_W-1:0];
                    r_pt_wrdata <= s_rddata ^ r_ct_q;
                    r_pt_wren   <= 1'b1;
                    if (!w_last) begin
                        r_k <= r_k + (ADDR_W+1)'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rdy       = (r_state == IDLE);
    assign s_addr    = r_s_addr;
    assign s_wrdata  = r_s_wrdata;
    assign s_wren    = r_s_wren;
    assign ct_addr   = r_ct_addr;
    assign pt_addr   = r_pt_addr;
    assign pt_wrdata = r_pt_wrdata;
    assign pt_wren   = r_pt_wren;

endmodule : rc4_prga
`default_nettype wire
